// File: rtl/ofmap_bram_reader.sv
// ofmap_bram_reader
// -----------------------------------------------------------------------------
// Readout engine for the GEMM output BRAM (MEM2). After GEMM signals finish,
// it reads all MEM2_DEPTH words in order through the BRAM's second port and
// streams them out on a valid/ready interface. A small FIFO absorbs both the
// one-cycle BRAM read latency and any downstream backpressure.
//
// Ports:
//   clk, rst_n   rising-edge clock, asynchronous active-low reset
//   start_i      begin a readout from IDLE (level or pulse)
//   mem2_ce1     BRAM port-1 chip enable (registered)
//   mem2_we1     BRAM port-1 write enable, tied to 0
//   mem2_addr1   BRAM port-1 read address (registered)
//   mem2_q1_i    BRAM port-1 read data, valid one cycle after ce
//   m_valid_o    output word valid (FIFO not empty)
//   m_ready_i    downstream ready
//   m_data_o     output word, passed through unmodified
//   m_last_o     flags the word read from address MEM2_DEPTH-1
//   busy_o       readout in progress
//   done_o       one-cycle pulse after the last word is accepted
// -----------------------------------------------------------------------------
module ofmap_bram_reader #(
   parameter int MEM2_DATA_WIDTH = 112,
   parameter int MEM2_DEPTH      = 896,
   parameter int MEM2_ADDR_WIDTH = 10,
   parameter int FIFO_DEPTH      = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       start_i,
   output logic                       mem2_ce1,
   output logic                       mem2_we1,
   output logic [MEM2_ADDR_WIDTH-1:0] mem2_addr1,
   input  logic [MEM2_DATA_WIDTH-1:0] mem2_q1_i,
   output logic                       m_valid_o,
   input  logic                       m_ready_i,
   output logic [MEM2_DATA_WIDTH-1:0] m_data_o,
   output logic                       m_last_o,
   output logic                       busy_o,
   output logic                       done_o
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam logic [MEM2_ADDR_WIDTH-1:0] LAST_ADDR = MEM2_ADDR_WIDTH'(MEM2_DEPTH - 1);

   typedef enum logic [1:0] {
      IDLE,
      READ,
      DRAIN
   } state_e;

   state_e                     state_q, state_d;
   logic [MEM2_ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [MEM2_ADDR_WIDTH-1:0] rdAddr_q, rdAddr_d;
   logic                       ce_q, ce_d;
   logic                       ceLast_q, ceLast_d;
   logic                       capt_q, captLast_q;
   logic                       done_q, done_d;

   logic [MEM2_DATA_WIDTH-1:0] fifoData_q [FIFO_DEPTH];
   logic                       fifoLast_q [FIFO_DEPTH];
   logic [PTR_W-1:0]           wrPtr_q, rdPtr_q;
   logic [PTR_W:0]             count_q;

   logic                       push, pop, headLast, issue;
   logic [MEM2_ADDR_WIDTH-1:0] issueAddr;
   logic [31:0]                occAfter;

   // capt_q marks the cycle in which BRAM data for an earlier ce is on the bus
   assign push     = capt_q;
   assign pop      = (count_q != '0) && m_ready_i;
   assign headLast = fifoLast_q[rdPtr_q];

   // Occupancy the FIFO will reach once every read already in flight lands,
   // counting a pop at this edge. A new read is only issued if it still fits.
   assign occAfter = 32'(count_q) + 32'(ce_q) + 32'(capt_q) - 32'(pop);

   // Next-state logic: read issue, address advance and completion detect
   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      rdAddr_d  = rdAddr_q;
      ce_d      = 1'b0;
      ceLast_d  = 1'b0;
      done_d    = 1'b0;
      issue     = 1'b0;
      issueAddr = addr_q;

      case (state_q)
         IDLE: begin
            if (start_i) begin
               issue     = 1'b1;
               issueAddr = '0;
            end
         end
         READ: begin
            if (occAfter < 32'(FIFO_DEPTH)) begin
               issue = 1'b1;
            end
         end
         DRAIN: begin
            if (pop && headLast) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      // The final address moves straight to DRAIN so the address never wraps
      if (issue) begin
         ce_d     = 1'b1;
         rdAddr_d = issueAddr;
         if (issueAddr == LAST_ADDR) begin
            ceLast_d = 1'b1;
            state_d  = DRAIN;
         end else begin
            addr_d  = issueAddr + MEM2_ADDR_WIDTH'(1);
            state_d = READ;
         end
      end
   end

   // Control registers and the two-stage read-latency pipeline
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         addr_q     <= '0;
         rdAddr_q   <= '0;
         ce_q       <= 1'b0;
         ceLast_q   <= 1'b0;
         capt_q     <= 1'b0;
         captLast_q <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         rdAddr_q   <= rdAddr_d;
         ce_q       <= ce_d;
         ceLast_q   <= ceLast_d;
         capt_q     <= ce_q;
         captLast_q <= ceLast_q;
         done_q     <= done_d;
      end
   end

   // FIFO pointers and occupancy; emptied by reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wrPtr_q <= '0;
         rdPtr_q <= '0;
         count_q <= '0;
      end else begin
         if (push) begin
            wrPtr_q <= wrPtr_q + PTR_W'(1);
         end
         if (pop) begin
            rdPtr_q <= rdPtr_q + PTR_W'(1);
         end
         case ({push, pop})
            2'b10:   count_q <= count_q + (PTR_W + 1)'(1);
            2'b01:   count_q <= count_q - (PTR_W + 1)'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // FIFO storage needs no reset: entries are only visible behind count_q
   always_ff @(posedge clk) begin
      if (push) begin
         fifoData_q[wrPtr_q] <= mem2_q1_i;
         fifoLast_q[wrPtr_q] <= captLast_q;
      end
   end

   assign m_valid_o  = (count_q != '0);
   assign m_data_o   = m_valid_o ? fifoData_q[rdPtr_q] : '0;
   assign m_last_o   = m_valid_o && headLast;
   assign busy_o     = (state_q != IDLE);
   assign done_o     = done_q;
   assign mem2_ce1   = ce_q;
   assign mem2_we1   = 1'b0;
   assign mem2_addr1 = rdAddr_q;

endmodule

// File: tb/tb_ofmap_bram_reader.sv
// tb_ofmap_bram_reader
// -----------------------------------------------------------------------------
// Directed bench for ofmap_bram_reader. A behavioural BRAM returns a pattern
// indexed by address (lane k = (addr+k) mod 256, lane 0 in the MSBs). A
// negedge monitor tallies accepted beats and data/last errors; each test
// task drives one scenario and compares the tallies against expectations.
// A second instance with MEM2_DEPTH=1 covers the single-word case.
// -----------------------------------------------------------------------------
module tb_ofmap_bram_reader;

   localparam int DW    = 112;
   localparam int AW    = 10;
   localparam int DEPTH = 896;

   logic          clk   = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic          ready = 1'b0;
   logic          ce, we, valid, last, busy, done;
   logic [AW-1:0] addr;
   logic [DW-1:0] q = '0;
   logic [DW-1:0] data;

   logic          s1Start = 1'b0;
   logic          s1Ready = 1'b1;
   logic          s1Ce, s1We, s1Valid, s1Last, s1Busy, s1Done;
   logic [AW-1:0] s1Addr;
   logic [DW-1:0] s1Q = '0;
   logic [DW-1:0] s1Data;

   int testsRun    = 0;
   int testsFailed = 0;

   int beats = 0, badData = 0, badLast = 0, lastBeats = 0, dones = 0;
   int ceReads = 0, lastCeAddr = 0, occBad = 0, weBad = 0, beatIdx = 0;

   ofmap_bram_reader #(
      .MEM2_DATA_WIDTH(DW), .MEM2_DEPTH(DEPTH), .MEM2_ADDR_WIDTH(AW), .FIFO_DEPTH(4)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start_i(start),
      .mem2_ce1(ce), .mem2_we1(we), .mem2_addr1(addr), .mem2_q1_i(q),
      .m_valid_o(valid), .m_ready_i(ready), .m_data_o(data), .m_last_o(last),
      .busy_o(busy), .done_o(done)
   );

   ofmap_bram_reader #(
      .MEM2_DATA_WIDTH(DW), .MEM2_DEPTH(1), .MEM2_ADDR_WIDTH(AW), .FIFO_DEPTH(4)
   ) dut1 (
      .clk(clk), .rst_n(rst_n), .start_i(s1Start),
      .mem2_ce1(s1Ce), .mem2_we1(s1We), .mem2_addr1(s1Addr), .mem2_q1_i(s1Q),
      .m_valid_o(s1Valid), .m_ready_i(s1Ready), .m_data_o(s1Data), .m_last_o(s1Last),
      .busy_o(s1Busy), .done_o(s1Done)
   );

   always #5 clk = ~clk;

   function automatic logic [DW-1:0] pattern(input int a);
      logic [DW-1:0] p;
      p = '0;
      for (int k = 0; k < DW / 8; k++) begin
         p[DW-1-8*k -: 8] = 8'((a + k) % 256);
      end
      return p;
   endfunction

   // Behavioural BRAMs with one-cycle registered read
   always @(posedge clk) begin
      if (ce) q <= pattern(int'(addr));
      if (s1Ce) s1Q <= pattern(int'(s1Addr));
   end

   // Sampling monitor: a handshake seen here completes at the next posedge
   always @(negedge clk) begin
      if (!rst_n) begin
         beatIdx = 0;
      end else begin
         if (ce) begin
            ceReads++;
            lastCeAddr = int'(addr);
         end
         if (we) weBad++;
         if (dut.count_q > 4) occBad++;
         if (done) dones++;
         if (valid && ready) begin
            beats++;
            if (data !== pattern(beatIdx)) badData++;
            if (last) lastBeats++;
            if (last !== (beatIdx == DEPTH - 1)) badLast++;
            beatIdx = (beatIdx == DEPTH - 1) ? 0 : beatIdx + 1;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic waitDone(input int maxCycles, output int cycles, output bit hit);
      cycles = 0;
      hit    = 1'b0;
      while (!hit && cycles < maxCycles) begin
         tick();
         cycles++;
         if (done) hit = 1'b1;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      tick();
      tick();
      testsRun++; if (valid !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_valid: got %b expected 0", valid); end
      testsRun++; if (busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
      testsRun++; if (done !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
      testsRun++; if (ce !== 1'b0 || we !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_ce_we: got %b%b expected 00", ce, we); end
      testsRun++; if (data !== '0 || last !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_data_last: got %h/%b expected 0/0", data, last); end
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_full_run();
      int b0, d0, bd0, bl0, lb0, cyc;
      bit hit;
      b0 = beats; d0 = dones; bd0 = badData; bl0 = badLast; lb0 = lastBeats;
      ready = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      testsRun++; if (ce !== 1'b1 || addr !== '0 || busy !== 1'b1) begin testsFailed++; $display("[TB] FAIL full_first_read: got ce=%b addr=%0d busy=%b expected 1/0/1", ce, addr, busy); end
      tick();
      testsRun++; if (valid !== 1'b0) begin testsFailed++; $display("[TB] FAIL full_valid_e1: got %b expected 0", valid); end
      tick();
      testsRun++; if (valid !== 1'b1 || data !== pattern(0)) begin testsFailed++; $display("[TB] FAIL full_first_word: got valid=%b data=%h expected 1/%h", valid, data, pattern(0)); end
      waitDone(1200, cyc, hit);
      testsRun++; if (!hit || cyc + 2 != DEPTH + 2) begin testsFailed++; $display("[TB] FAIL full_done_latency: got %0d edges (seen=%b) expected %0d", cyc + 2, hit, DEPTH + 2); end
      testsRun++; if (busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL full_busy_at_done: got %b expected 0", busy); end
      tick();
      tick();
      testsRun++; if (beats - b0 != DEPTH) begin testsFailed++; $display("[TB] FAIL full_beats: got %0d expected %0d", beats - b0, DEPTH); end
      testsRun++; if (badData - bd0 != 0 || badLast - bl0 != 0) begin testsFailed++; $display("[TB] FAIL full_data_last: got %0d/%0d errors expected 0/0", badData - bd0, badLast - bl0); end
      testsRun++; if (lastBeats - lb0 != 1 || dones - d0 != 1) begin testsFailed++; $display("[TB] FAIL full_last_done_count: got %0d/%0d expected 1/1", lastBeats - lb0, dones - d0); end
   endtask

   task automatic test_backpressure();
      int b0, d0, bd0, r0, cyc;
      bit hit;
      b0 = beats; d0 = dones; bd0 = badData; r0 = ceReads;
      ready = 1'b0;
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (20) tick();
      testsRun++; if (ceReads - r0 != 4 || lastCeAddr != 3) begin testsFailed++; $display("[TB] FAIL bp_reads: got %0d reads last addr %0d expected 4 / 3", ceReads - r0, lastCeAddr); end
      testsRun++; if (ce !== 1'b0) begin testsFailed++; $display("[TB] FAIL bp_ce_idle: got %b expected 0", ce); end
      testsRun++; if (valid !== 1'b1 || data !== pattern(0)) begin testsFailed++; $display("[TB] FAIL bp_head: got valid=%b data=%h expected 1/%h", valid, data, pattern(0)); end
      repeat (5) tick();
      testsRun++; if (data !== pattern(0) || last !== 1'b0) begin testsFailed++; $display("[TB] FAIL bp_data_stable: got %h/%b expected %h/0", data, last, pattern(0)); end
      ready = 1'b1;
      waitDone(1200, cyc, hit);
      tick();
      testsRun++; if (!hit || beats - b0 != DEPTH || dones - d0 != 1) begin testsFailed++; $display("[TB] FAIL bp_drain: got beats=%0d dones=%0d seen=%b expected %0d/1/1", beats - b0, dones - d0, hit, DEPTH); end
      testsRun++; if (badData - bd0 != 0) begin testsFailed++; $display("[TB] FAIL bp_order: got %0d data errors expected 0", badData - bd0); end
   endtask

   task automatic test_random_ready();
      int b0, d0, bd0, bl0, n;
      bit hit;
      b0 = beats; d0 = dones; bd0 = badData; bl0 = badLast;
      n = 0;
      hit = 1'b0;
      void'($urandom(32'd1234));
      start = 1'b1;
      tick();
      start = 1'b0;
      while (!hit && n < 5000) begin
         ready = 1'($urandom_range(0, 1));
         tick();
         n++;
         if (done) hit = 1'b1;
      end
      ready = 1'b1;
      tick();
      testsRun++; if (!hit || beats - b0 != DEPTH) begin testsFailed++; $display("[TB] FAIL rand_beats: got %0d (seen=%b) expected %0d", beats - b0, hit, DEPTH); end
      testsRun++; if (badData - bd0 != 0 || badLast - bl0 != 0) begin testsFailed++; $display("[TB] FAIL rand_order: got %0d/%0d errors expected 0/0", badData - bd0, badLast - bl0); end
      testsRun++; if (occBad != 0 || weBad != 0) begin testsFailed++; $display("[TB] FAIL rand_occ_we: got %0d/%0d violations expected 0/0", occBad, weBad); end
      testsRun++; if (dones - d0 != 1) begin testsFailed++; $display("[TB] FAIL rand_done: got %0d expected 1", dones - d0); end
   endtask

   task automatic test_back_to_back();
      int b0, d0, bd0, cyc, n;
      bit hit;
      b0 = beats; d0 = dones; bd0 = badData;
      ready = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      n = 0;
      while (beats - b0 < 100 && n < 300) begin
         tick();
         n++;
      end
      start = 1'b1;
      tick();
      start = 1'b0;
      waitDone(1200, cyc, hit);
      repeat (3) tick();
      testsRun++; if (!hit || beats - b0 != DEPTH || dones - d0 != 1) begin testsFailed++; $display("[TB] FAIL retrig_ignored: got beats=%0d dones=%0d expected %0d/1", beats - b0, dones - d0, DEPTH); end

      b0 = beats; d0 = dones;
      start = 1'b1;
      tick();
      waitDone(1200, cyc, hit);
      tick();
      testsRun++; if (!hit || ce !== 1'b1 || addr !== '0 || busy !== 1'b1) begin testsFailed++; $display("[TB] FAIL level_restart: got ce=%b addr=%0d busy=%b seen=%b expected 1/0/1/1", ce, addr, busy, hit); end
      start = 1'b0;
      waitDone(1200, cyc, hit);
      tick();
      testsRun++; if (!hit || beats - b0 != 2 * DEPTH || dones - d0 != 2 || badData - bd0 != 0) begin testsFailed++; $display("[TB] FAIL level_two_runs: got beats=%0d dones=%0d errs=%0d expected %0d/2/0", beats - b0, dones - d0, badData - bd0, 2 * DEPTH); end
   endtask

   task automatic test_reset_abort();
      int b0, d0, bd0, cyc, n;
      bit hit;
      b0 = beats;
      ready = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      n = 0;
      while (beats - b0 < 400 && n < 600) begin
         tick();
         n++;
      end
      d0 = dones;
      rst_n = 1'b0;
      #1;
      testsRun++; if (valid !== 1'b0 || ce !== 1'b0 || busy !== 1'b0 || data !== '0 || last !== 1'b0) begin testsFailed++; $display("[TB] FAIL abort_outputs: got valid=%b ce=%b busy=%b last=%b expected all 0", valid, ce, busy, last); end
      tick();
      tick();
      rst_n = 1'b1;
      repeat (3) tick();
      testsRun++; if (dones - d0 != 0 || busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL abort_no_done: got dones=%0d busy=%b expected 0/0", dones - d0, busy); end
      b0 = beats; bd0 = badData; d0 = dones;
      start = 1'b1;
      tick();
      start = 1'b0;
      testsRun++; if (ce !== 1'b1 || addr !== '0) begin testsFailed++; $display("[TB] FAIL abort_restart_addr: got ce=%b addr=%0d expected 1/0", ce, addr); end
      waitDone(1200, cyc, hit);
      tick();
      testsRun++; if (!hit || beats - b0 != DEPTH || badData - bd0 != 0 || dones - d0 != 1) begin testsFailed++; $display("[TB] FAIL abort_rerun: got beats=%0d errs=%0d dones=%0d expected %0d/0/1", beats - b0, badData - bd0, dones - d0, DEPTH); end
   endtask

   task automatic test_depth_one();
      s1Start = 1'b1;
      tick();
      s1Start = 1'b0;
      testsRun++; if (s1Ce !== 1'b1 || s1Addr !== '0 || s1Busy !== 1'b1 || s1We !== 1'b0) begin testsFailed++; $display("[TB] FAIL d1_read: got ce=%b addr=%0d busy=%b expected 1/0/1", s1Ce, s1Addr, s1Busy); end
      tick();
      testsRun++; if (s1Ce !== 1'b0 || s1Valid !== 1'b0) begin testsFailed++; $display("[TB] FAIL d1_single_read: got ce=%b valid=%b expected 0/0", s1Ce, s1Valid); end
      tick();
      testsRun++; if (s1Valid !== 1'b1 || s1Last !== 1'b1 || s1Data !== pattern(0)) begin testsFailed++; $display("[TB] FAIL d1_beat: got valid=%b last=%b data=%h expected 1/1/%h", s1Valid, s1Last, s1Data, pattern(0)); end
      tick();
      testsRun++; if (s1Done !== 1'b1 || s1Valid !== 1'b0 || s1Busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL d1_done: got done=%b valid=%b busy=%b expected 1/0/0", s1Done, s1Valid, s1Busy); end
      tick();
      testsRun++; if (s1Done !== 1'b0) begin testsFailed++; $display("[TB] FAIL d1_done_pulse: got %b expected 0", s1Done); end
   endtask

   initial begin
      test_reset();
      test_full_run();
      test_backpressure();
      test_random_ready();
      test_back_to_back();
      test_reset_abort();
      test_depth_one();
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
